alu_exec_unit: RTL and testbench
================================

// Module: alu_exec_unit
// PURPOSE
//   Registered execute stage directly downstream of the ALU controller.
//   - Consumes the 4-bit ALU control code and two operands through a valid/ready handshake.
//   - Returns a registered result with zero/overflow flags and a one-cycle done pulse.
//   - Single-cycle ops complete in 1 cycle; optional iterative unsigned multiply fills HI/LO.
// PARAMETERS
//   DATA_W   32   operand/result width; multiply takes DATA_W iterations
// PORTS
//   clk_i       in   1        clock, rising edge
//   rst_i       in   1        asynchronous, active-low reset
//   valid_i     in   1        request valid; accepted when valid_i & ready_o
//   ready_o     out  1        unit idle and able to accept
//   ALUCtrl_i   in   4        op: 0000 AND, 0001 OR, 0010 ADD, 0110 SUB, 0111 SLT, 1100 NOR, 1000 MULTU
//   src1_i      in   DATA_W   operand A
//   src2_i      in   DATA_W   operand B
//   result_o    out  DATA_W   registered result; held until next completion
//   zero_o      out  1        result_o == 0; registered with result_o
//   overflow_o  out  1        signed overflow, ADD/SUB only; 0 for all other ops
//   done_o      out  1        one-cycle pulse when result_o/flags update
//   hi_o        out  DATA_W   upper product word, last completed MULTU
//   lo_o        out  DATA_W   lower product word, last completed MULTU
// BEHAVIOUR
//   Reset (rst_i=0, async):
//     - state IDLE; ready_o=1; done_o=0; overflow_o=0.
//     - result_o, hi_o, lo_o = 0; zero_o=1 (consistent with result 0).
//   FSM states: IDLE, MUL, DONE.
//   IDLE:
//     - Capture operands and code on accept.
//     - MULTU -> MUL; any other code -> DONE.
//   Single-cycle ops (AND/OR/ADD/SUB/SLT/NOR, plus undefined codes):
//     - Result computed from captured operands; written at the accept edge.
//     - Accept edge -> DONE: done_o=1 for exactly the cycle after accept.
//     - DONE -> IDLE unconditionally.
//   Latency and throughput:
//     - 1 cycle accept-to-done; throughput one op per 2 cycles.
//     - ready_o=1 only in IDLE.
//   Arithmetic:
//     - ADD/SUB wrap modulo 2^DATA_W.
//     - overflow_o = operand signs match (SUB: A vs ~B) and result sign differs.
//     - SLT is a signed compare, = diff[MSB] XOR overflow; correct even when A-B overflows.
//     - SLT result is zero-extended 0/1.
//     - NOR = ~(A|B).
//     - Undefined codes: result 0, zero_o=1, overflow_o=0, still one done pulse.
//   MULTU (1000, macro on):
//     - Unsigned shift-add, one multiplier bit per cycle.
//     - MUL runs exactly DATA_W cycles, then DONE.
//     - done_o asserts DATA_W+1 cycles after accept (33 at default).
//     - On done: hi_o/lo_o get the 2*DATA_W product; result_o=lo_o; zero_o from result_o; overflow_o=0.
//     - hi_o/lo_o change only on MULTU completion or reset.
//   Boundary conditions:
//     - valid_i while ready_o=0: ignored (not queued); requester must hold valid_i.
//     - Inputs change after accept: no effect; operands are captured.
//     - Reset mid-MUL: aborts immediately to reset values; no done pulse; partial product discarded.
//     - Operand 0 or all-ones: no early termination; latency is fixed.
// CONFIGURATION
//   ALU_EXEC_MULT_EN defined:
//     - MULTU datapath, MUL state and iteration counter present, as above.
//   ALU_EXEC_MULT_EN undefined:
//     - 1000 treated as an undefined code (1-cycle done, result 0).
//     - hi_o/lo_o tied to 0; MUL state unreachable.
// TESTING
//   1. ADD 7+5 accepted at edge N -> done_o=1 at cycle N+1, result_o=12, zero_o=0, overflow_o=0.
//   2. SUB 0x7FFFFFFF-0xFFFFFFFF -> result 0x80000000, overflow_o=1; then SUB 5-5 -> result 0, zero_o=1.
//   3. SLT 0xFFFFFFFF,1 -> 1; SLT 0x80000000,1 -> 1 (overflow case); SLT 1,0xFFFFFFFF -> 0.
//   4. MULTU 0xFFFFFFFF*2 (macro on) -> ready_o=0 for 33 cycles, done 33 cycles after accept,
//      hi_o=1, lo_o=result_o=0xFFFFFFFE; valid_i pulses while busy ignored.
//   5. Reset at cycle 10 of MULTU -> ready_o=1, done_o=0, hi_o=lo_o=result_o=0 at once;
//      next ADD 1+1 -> 2 after 1 cycle.
//   6. Code 1000 with macro off, and code 1111 -> done after 1 cycle, result 0, zero_o=1, hi_o=lo_o=0.

Source files
------------

// File: rtl/alu_exec_unit.sv
// rtl/alu_exec_unit.sv - registered ALU execute stage with valid/ready accept and done pulse
// Optional iterative unsigned multiply (HI/LO) enabled by defining ALU_EXEC_MULT_EN.
module alu_exec_unit #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  output logic              ready_o,
  input  logic [3:0]        ALUCtrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              overflow_o,
  output logic              done_o,
  output logic [DATA_W-1:0] hi_o,
  output logic [DATA_W-1:0] lo_o
);

  localparam int MSB = DATA_W - 1;

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_OR    = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_SLT   = 4'b0111;
  localparam logic [3:0] OP_NOR   = 4'b1100;
  localparam logic [3:0] OP_MULTU = 4'b1000;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;
  state_t state;

  logic [DATA_W-1:0] sum;
  logic [DATA_W-1:0] diff;
  logic              add_ovf;
  logic              sub_ovf;
  logic [DATA_W-1:0] alu_res;
  logic              alu_ovf;
  logic              is_mul;

  assign sum  = src1_i + src2_i;
  assign diff = src1_i - src2_i;

  // Subtraction overflows when A and ~B share a sign, i.e. A and B differ in sign.
  assign add_ovf = (src1_i[MSB] == src2_i[MSB]) && (sum[MSB]  != src1_i[MSB]);
  assign sub_ovf = (src1_i[MSB] != src2_i[MSB]) && (diff[MSB] != src1_i[MSB]);

  always_comb begin
    alu_res = '0;
    alu_ovf = 1'b0;
    case (ALUCtrl_i)
      OP_AND: alu_res = src1_i & src2_i;
      OP_OR:  alu_res = src1_i | src2_i;
      OP_ADD: begin
        alu_res = sum;
        alu_ovf = add_ovf;
      end
      OP_SUB: begin
        alu_res = diff;
        alu_ovf = sub_ovf;
      end
      OP_SLT: alu_res = {{(DATA_W-1){1'b0}}, diff[MSB] ^ sub_ovf};
      OP_NOR: alu_res = ~(src1_i | src2_i);
      default: begin
        alu_res = '0;
        alu_ovf = 1'b0;
      end
    endcase
  end

`ifdef ALU_EXEC_MULT_EN
  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0]   mcand;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_next;
  logic [DATA_W:0]     upper_sum;
  logic [CNT_W-1:0]    cnt;

  // Product register starts as {0, multiplier}; each step adds into the top half and shifts right.
  assign upper_sum = {1'b0, prod[2*DATA_W-1:DATA_W]} + {1'b0, (prod[0] ? mcand : {DATA_W{1'b0}})};
  assign prod_next = {upper_sum, prod[DATA_W-1:1]};
  assign is_mul    = (ALUCtrl_i == OP_MULTU);
`else
  assign is_mul = 1'b0;
  assign hi_o   = '0;
  assign lo_o   = '0;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      ready_o    <= 1'b1;
      done_o     <= 1'b0;
      result_o   <= '0;
      zero_o     <= 1'b1;
      overflow_o <= 1'b0;
`ifdef ALU_EXEC_MULT_EN
      hi_o       <= '0;
      lo_o       <= '0;
      mcand      <= '0;
      prod       <= '0;
      cnt        <= '0;
`endif
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (valid_i) begin
            ready_o <= 1'b0;
            if (is_mul) begin
`ifdef ALU_EXEC_MULT_EN
              mcand <= src1_i;
              prod  <= {{DATA_W{1'b0}}, src2_i};
              cnt   <= '0;
`endif
              state <= MUL;
            end else begin
              result_o   <= alu_res;
              zero_o     <= (alu_res == '0);
              overflow_o <= alu_ovf;
              done_o     <= 1'b1;
              state      <= DONE;
            end
          end
        end
`ifdef ALU_EXEC_MULT_EN
        MUL: begin
          prod <= prod_next;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(DATA_W - 1)) begin
            hi_o       <= prod_next[2*DATA_W-1:DATA_W];
            lo_o       <= prod_next[DATA_W-1:0];
            result_o   <= prod_next[DATA_W-1:0];
            zero_o     <= (prod_next[DATA_W-1:0] == '0);
            overflow_o <= 1'b0;
            done_o     <= 1'b1;
            state      <= DONE;
          end
        end
`endif
        DONE: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
        default: begin
          state   <= IDLE;
          ready_o <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
// tb/tb_alu_exec_unit.sv - self-checking bench for alu_exec_unit against a cycle-count reference model
// Follows ALU_EXEC_MULT_EN so the expected MULTU behaviour matches the build.
module tb_alu_exec_unit;

`ifdef ALU_EXEC_MULT_EN
  localparam bit MULT_EN = 1'b1;
`else
  localparam bit MULT_EN = 1'b0;
`endif
  localparam int MUL_LAT = 33;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        valid_i = 1'b0;
  logic [3:0]  ALUCtrl_i = 4'b0;
  logic [31:0] src1_i = '0;
  logic [31:0] src2_i = '0;
  logic        ready_o;
  logic [31:0] result_o;
  logic        zero_o;
  logic        overflow_o;
  logic        done_o;
  logic [31:0] hi_o;
  logic [31:0] lo_o;

  alu_exec_unit #(.DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .ready_o(ready_o),
    .ALUCtrl_i(ALUCtrl_i), .src1_i(src1_i), .src2_i(src2_i),
    .result_o(result_o), .zero_o(zero_o), .overflow_o(overflow_o),
    .done_o(done_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: m_cnt counts cycles left until the unit is idle; done is the last one.
  int          m_cnt  = 0;
  logic [31:0] m_res  = '0;
  logic        m_zero = 1'b1;
  logic        m_ovf  = 1'b0;
  logic [31:0] m_hi   = '0;
  logic [31:0] m_lo   = '0;
  logic [31:0] p_res, p_hi, p_lo;
  logic        p_ovf;
  bit          p_mul;

  function automatic void model_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                   output logic [31:0] r, output logic v,
                                   output logic [31:0] hi, output logic [31:0] lo, output bit mul);
    logic signed [63:0] sa;
    logic signed [63:0] sb;
    logic signed [63:0] s;
    logic [63:0] p;
    sa = 64'(signed'(a));
    sb = 64'(signed'(b));
    s = '0;
    p = '0;
    r = '0; v = 1'b0; hi = '0; lo = '0; mul = 1'b0;
    case (op)
      4'b0000: r = a & b;
      4'b0001: r = a | b;
      4'b0010: begin
        s = sa + sb;
        r = s[31:0];
        v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
      end
      4'b0110: begin
        s = sa - sb;
        r = s[31:0];
        v = (s > 64'sh7FFF_FFFF) || (s < -64'sh8000_0000);
      end
      4'b0111: r = (sa < sb) ? 32'd1 : 32'd0;
      4'b1100: r = ~(a | b);
      4'b1000: if (MULT_EN) begin
        p = {32'b0, a} * {32'b0, b};
        hi = p[63:32];
        lo = p[31:0];
        r = lo;
        mul = 1'b1;
      end
      default: r = '0;
    endcase
  endfunction

  always @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      m_cnt = 0; m_res = '0; m_zero = 1'b1; m_ovf = 1'b0; m_hi = '0; m_lo = '0;
    end else begin
      if (m_cnt == 0) begin
        if (valid_i) begin
          model_op(ALUCtrl_i, src1_i, src2_i, p_res, p_ovf, p_hi, p_lo, p_mul);
          m_cnt = p_mul ? MUL_LAT : 1;
        end
      end else begin
        m_cnt = m_cnt - 1;
      end
      if (m_cnt == 1) begin
        m_res = p_res; m_zero = (p_res == 0); m_ovf = p_ovf;
        if (p_mul) begin m_hi = p_hi; m_lo = p_lo; end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_cycle();
    check("ready", 64'(ready_o), 64'(m_cnt == 0));
    check("done", 64'(done_o), 64'(m_cnt == 1));
    check("result", 64'(result_o), 64'(m_res));
    check("zero", 64'(zero_o), 64'(m_zero));
    check("overflow", 64'(overflow_o), 64'(m_ovf));
    check("hi", 64'(hi_o), 64'(m_hi));
    check("lo", 64'(lo_o), 64'(m_lo));
  endtask

  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    n = 0;
    while (!ready_o && n < 100) begin @(negedge clk_i); n++; end
    if (!ready_o) check("ready_timeout", 64'(ready_o), 64'd1);
    valid_i = 1'b1; ALUCtrl_i = op; src1_i = a; src2_i = b;
    @(negedge clk_i);
    valid_i = 1'b0; ALUCtrl_i = 4'($urandom); src1_i = $urandom; src2_i = $urandom;
  endtask

  task automatic do_op(input string name, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] er, input logic eo, input logic ez, input int el, input bit pulse);
    int n;
    issue(op, a, b);
    n = 1;
    while (!done_o && n < 100) begin
      if (pulse) begin valid_i = n[0]; ALUCtrl_i = 4'b0010; end
      @(negedge clk_i);
      n++;
    end
    valid_i = 1'b0;
    check({name, "_lat"}, 64'(n), 64'(el));
    check({name, "_res"}, 64'(result_o), 64'(er));
    check({name, "_ovf"}, 64'(overflow_o), 64'(eo));
    check({name, "_zero"}, 64'(zero_o), 64'(ez));
    check({name, "_model"}, 64'(m_res), 64'(er));
  endtask

  logic [3:0] op_tab [10] = '{4'h0, 4'h1, 4'h2, 4'h6, 4'h7, 4'hC, 4'h8, 4'hF, 4'h3, 4'h9};

  function automatic logic [31:0] pick_operand();
    case ($urandom_range(0, 7))
      0: return 32'h0000_0000;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'h7FFF_FFFF;
      4: return 32'h0000_0001;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #3 rst_i = 1'b0;
    #1;
    fork
      forever begin
        @(negedge clk_i);
        cmp_cycle();
      end
    join_none
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;
    check("rst_ready", 64'(ready_o), 64'd1);
    check("rst_done", 64'(done_o), 64'd0);
    check("rst_result", 64'(result_o), 64'd0);
    check("rst_zero", 64'(zero_o), 64'd1);
    check("rst_hi", 64'(hi_o), 64'd0);
    @(negedge clk_i);

    do_op("add", 4'b0010, 32'd7, 32'd5, 32'd12, 1'b0, 1'b0, 1, 1'b0);
    do_op("sub_ovf", 4'b0110, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1, 1'b0, 1, 1'b0);
    do_op("sub_zero", 4'b0110, 32'd5, 32'd5, 32'd0, 1'b0, 1'b1, 1, 1'b0);
    do_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0, 1'b0, 1, 1'b0);
    do_op("slt_ovf", 4'b0111, 32'h8000_0000, 32'd1, 32'd1, 1'b0, 1'b0, 1, 1'b0);
    do_op("slt_pos", 4'b0111, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, 1, 1'b0);
    do_op("nor", 4'b1100, 32'hF0F0_0000, 32'h0F00_00FF, 32'h000F_FF00, 1'b0, 1'b0, 1, 1'b0);
    do_op("and", 4'b0000, 32'hF0F0_1234, 32'hFF00_FFFF, 32'hF000_1234, 1'b0, 1'b0, 1, 1'b0);
    do_op("undef_f", 4'b1111, 32'h1234_5678, 32'h1111_1111, 32'd0, 1'b0, 1'b1, 1, 1'b0);

`ifdef ALU_EXEC_MULT_EN
    do_op("multu", 4'b1000, 32'hFFFF_FFFF, 32'd2, 32'hFFFF_FFFE, 1'b0, 1'b0, MUL_LAT, 1'b1);
    check("multu_hi", 64'(hi_o), 64'd1);
    check("multu_lo", 64'(lo_o), 64'hFFFF_FFFE);
    do_op("multu_zero", 4'b1000, 32'd0, 32'hFFFF_FFFF, 32'd0, 1'b0, 1'b1, MUL_LAT, 1'b0);
    issue(4'b1000, 32'h1234_5678, 32'h9ABC_DEF0);
    repeat (9) @(negedge clk_i);
`else
    do_op("multu_off", 4'b1000, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0, 1'b1, 1, 1'b0);
    check("multu_off_hi", 64'(hi_o), 64'd0);
    check("multu_off_lo", 64'(lo_o), 64'd0);
    do_op("pre_rst", 4'b0001, 32'h00F0, 32'h0F00, 32'h0FF0, 1'b0, 1'b0, 1, 1'b0);
`endif
    #2 rst_i = 1'b0;
    #1;
    check("midrst_ready", 64'(ready_o), 64'd1);
    check("midrst_done", 64'(done_o), 64'd0);
    check("midrst_result", 64'(result_o), 64'd0);
    check("midrst_zero", 64'(zero_o), 64'd1);
    check("midrst_hi", 64'(hi_o), 64'd0);
    check("midrst_lo", 64'(lo_o), 64'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    do_op("post_rst_add", 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1, 1'b0);

    for (int i = 0; i < 2000; i++) begin
      valid_i   = ($urandom_range(0, 3) != 0);
      ALUCtrl_i = op_tab[$urandom_range(0, 9)];
      src1_i    = pick_operand();
      src2_i    = pick_operand();
      @(negedge clk_i);
    end
    valid_i = 1'b0;
    repeat (40) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
